// File: rtl/uart_core_param_pkg.sv
// Shared constants, state encodings and parity helper for the parameterised UART core.
package uart_core_param_pkg;

    localparam int unsigned PAR_NONE      = 0;
    localparam int unsigned PAR_EVEN      = 1;
    localparam int unsigned PAR_ODD       = 2;
    localparam int unsigned OVERSAMPLE    = 16;
    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Callers zero-extend the payload to MAX_DATA_BITS; only the low nbits contribute.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int unsigned              nbits,
                                         input int unsigned              mode);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick: one-clk pulse every CLK_FREQ/(BAUD_RATE*16) clocks.
module uart_baud_gen #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    import uart_core_param_pkg::*;

    localparam int unsigned TICK_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TICK_DIV     = (TICK_DIV_RAW == 0) ? 1 : TICK_DIV_RAW;
    localparam int unsigned CNT_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_core_param.sv
// Parameterised full-duplex UART: independent TX and RX state machines driven by
// one shared 16x oversample tick.
module uart_core_param #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    import uart_core_param_pkg::*;

    localparam logic [3:0]  TICK_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  HALF_LAST  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);
    localparam uart_state_e AFTER_DATA = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;

    logic tick;

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_baud_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    uart_state_e            tx_state_q, tx_state_d;
    logic [3:0]             tx_tick_cnt_q, tx_tick_cnt_d;
    logic [3:0]             tx_bit_cnt_q, tx_bit_cnt_d;
    logic [DATA_BITS-1:0]   tx_shreg_q, tx_shreg_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_bit_end;
    logic [MAX_DATA_BITS-1:0] tx_data_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q    <= ST_IDLE;
            tx_tick_cnt_q <= '0;
            tx_bit_cnt_q  <= '0;
            tx_shreg_q    <= '0;
            tx_par_q      <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_tick_cnt_q <= tx_tick_cnt_d;
            tx_bit_cnt_q  <= tx_bit_cnt_d;
            tx_shreg_q    <= tx_shreg_d;
            tx_par_q      <= tx_par_d;
        end
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_tick_cnt_d = tx_tick_cnt_q;
        tx_bit_cnt_d  = tx_bit_cnt_q;
        tx_shreg_d    = tx_shreg_q;
        tx_par_d      = tx_par_q;
        tx_data_ext   = '0;
        tx_data_ext[DATA_BITS-1:0] = tx_data;
        tx_bit_end    = tick && (tx_tick_cnt_q == TICK_LAST);
        // 4-bit counter wraps after 16 ticks, so each bit boundary is simply count==15 on a tick.
        if (tick && (tx_state_q != ST_IDLE)) tx_tick_cnt_d = tx_tick_cnt_q + 4'd1;
        unique case (tx_state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    tx_state_d    = ST_START;
                    tx_shreg_d    = tx_data;
                    tx_par_d      = calc_parity(tx_data_ext, DATA_BITS, PARITY);
                    tx_tick_cnt_d = '0;
                    tx_bit_cnt_d  = '0;
                end
            end
            ST_START: begin
                if (tx_bit_end) tx_state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    tx_shreg_d = tx_shreg_q >> 1;
                    if (tx_bit_cnt_q == DATA_LAST) begin
                        tx_bit_cnt_d = '0;
                        tx_state_d   = AFTER_DATA;
                    end else begin
                        tx_bit_cnt_d = tx_bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tx_bit_end) tx_state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_cnt_q == STOP_LAST) tx_state_d = ST_IDLE;
                    else                           tx_bit_cnt_d = tx_bit_cnt_q + 4'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_busy = (tx_state_q != ST_IDLE);
        unique case (tx_state_q)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = tx_shreg_q[0];
            ST_PARITY: tx = tx_par_q;
            default:   tx = 1'b1;
        endcase
    end

    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_sync_q, rx_sync_d;
    uart_state_e            rx_state_q, rx_state_d;
    logic [3:0]             rx_tick_cnt_q, rx_tick_cnt_d;
    logic [3:0]             rx_bit_cnt_q, rx_bit_cnt_d;
    logic [DATA_BITS-1:0]   rx_shreg_q, rx_shreg_d;
    logic                   rx_armed_q, rx_armed_d;
    logic                   rx_perr_acc_q, rx_perr_acc_d;
    logic                   rx_ferr_acc_q, rx_ferr_acc_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   rx_parity_err_q, rx_parity_err_d;
    logic                   rx_frame_err_q, rx_frame_err_d;
    logic                   rx_bit_end;
    logic [MAX_DATA_BITS-1:0] rx_shreg_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            rx_state_q      <= ST_IDLE;
            rx_tick_cnt_q   <= '0;
            rx_bit_cnt_q    <= '0;
            rx_shreg_q      <= '0;
            rx_armed_q      <= 1'b0;
            rx_perr_acc_q   <= 1'b0;
            rx_ferr_acc_q   <= 1'b0;
            rx_data_q       <= '0;
            rx_done_q       <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q       <= rx_meta_d;
            rx_sync_q       <= rx_sync_d;
            rx_state_q      <= rx_state_d;
            rx_tick_cnt_q   <= rx_tick_cnt_d;
            rx_bit_cnt_q    <= rx_bit_cnt_d;
            rx_shreg_q      <= rx_shreg_d;
            rx_armed_q      <= rx_armed_d;
            rx_perr_acc_q   <= rx_perr_acc_d;
            rx_ferr_acc_q   <= rx_ferr_acc_d;
            rx_data_q       <= rx_data_d;
            rx_done_q       <= rx_done_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
        end
    end

    always_comb begin
        rx_meta_d       = rx;
        rx_sync_d       = rx_meta_q;
        rx_state_d      = rx_state_q;
        rx_tick_cnt_d   = rx_tick_cnt_q;
        rx_bit_cnt_d    = rx_bit_cnt_q;
        rx_shreg_d      = rx_shreg_q;
        rx_armed_d      = 1'b0;
        rx_perr_acc_d   = rx_perr_acc_q;
        rx_ferr_acc_d   = rx_ferr_acc_q;
        rx_data_d       = rx_data_q;
        rx_done_d       = 1'b0;
        rx_parity_err_d = rx_parity_err_q;
        rx_frame_err_d  = rx_frame_err_q;
        rx_shreg_ext    = '0;
        rx_shreg_ext[DATA_BITS-1:0] = rx_shreg_q;
        rx_bit_end      = tick && (rx_tick_cnt_q == TICK_LAST);
        if (tick && (rx_state_q != ST_IDLE)) rx_tick_cnt_d = rx_tick_cnt_q + 4'd1;
        unique case (rx_state_q)
            ST_IDLE: begin
                // A start needs a high-to-low edge, so a held-low (break) line cannot retrigger.
                rx_armed_d = rx_sync_q;
                if (rx_armed_q && !rx_sync_q) begin
                    rx_state_d    = ST_START;
                    rx_tick_cnt_d = '0;
                    rx_perr_acc_d = 1'b0;
                    rx_ferr_acc_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick && (rx_tick_cnt_q == HALF_LAST)) begin
                    rx_tick_cnt_d = '0;
                    rx_bit_cnt_d  = '0;
                    rx_state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_shreg_d = {rx_sync_q, rx_shreg_q[DATA_BITS-1:1]};
                    if (rx_bit_cnt_q == DATA_LAST) begin
                        rx_bit_cnt_d = '0;
                        rx_state_d   = AFTER_DATA;
                    end else begin
                        rx_bit_cnt_d = rx_bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_bit_end) begin
                    rx_perr_acc_d = rx_sync_q ^ calc_parity(rx_shreg_ext, DATA_BITS, PARITY);
                    rx_state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_bit_end) begin
                    rx_ferr_acc_d = rx_ferr_acc_q | ~rx_sync_q;
                    if (rx_bit_cnt_q == STOP_LAST) begin
                        rx_state_d      = ST_IDLE;
                        rx_data_d       = rx_shreg_q;
                        rx_parity_err_d = rx_perr_acc_q;
                        rx_frame_err_d  = rx_ferr_acc_d;
                        rx_done_d       = 1'b1;
                    end else begin
                        rx_bit_cnt_d = rx_bit_cnt_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_data       = rx_data_q;
        rx_done       = rx_done_q;
        rx_parity_err = rx_parity_err_q;
        rx_frame_err  = rx_frame_err_q;
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: 8N1, 8E1 loopback, 8O1 and 8N2 instances
// at 10 clk per tick (160 clk per bit).
module tb_uart_core_param;

    localparam int unsigned CF       = 1_600_000;
    localparam int unsigned BR       = 10_000;
    localparam int          BIT_CLKS = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       tx_start_n1 = 1'b0, tx_start_e1 = 1'b0, tx_start_o1 = 1'b0, tx_start_n2 = 1'b0;
    logic [7:0] tx_data_n1 = '0, tx_data_e1 = '0, tx_data_o1 = '0, tx_data_n2 = '0;
    logic       tx_n1, tx_e1, tx_o1, tx_n2;
    logic       tx_busy_n1, tx_busy_e1, tx_busy_o1, tx_busy_n2;
    logic       rx_n1 = 1'b1, rx_o1 = 1'b1, rx_n2 = 1'b1;
    logic       rx_e1;
    logic [7:0] rx_data_n1, rx_data_e1, rx_data_o1, rx_data_n2;
    logic       rx_done_n1, rx_done_e1, rx_done_o1, rx_done_n2;
    logic       rx_perr_n1, rx_perr_e1, rx_perr_o1, rx_perr_n2;
    logic       rx_ferr_n1, rx_ferr_e1, rx_ferr_o1, rx_ferr_n2;

    assign rx_e1 = tx_e1;

    uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n1 (
        .clk(clk), .rst(rst), .tx_start(tx_start_n1), .tx_data(tx_data_n1), .tx(tx_n1), .tx_busy(tx_busy_n1),
        .rx(rx_n1), .rx_data(rx_data_n1), .rx_done(rx_done_n1), .rx_parity_err(rx_perr_n1), .rx_frame_err(rx_ferr_n1));
    uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e1 (
        .clk(clk), .rst(rst), .tx_start(tx_start_e1), .tx_data(tx_data_e1), .tx(tx_e1), .tx_busy(tx_busy_e1),
        .rx(rx_e1), .rx_data(rx_data_e1), .rx_done(rx_done_e1), .rx_parity_err(rx_perr_e1), .rx_frame_err(rx_ferr_e1));
    uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_o1 (
        .clk(clk), .rst(rst), .tx_start(tx_start_o1), .tx_data(tx_data_o1), .tx(tx_o1), .tx_busy(tx_busy_o1),
        .rx(rx_o1), .rx_data(rx_data_o1), .rx_done(rx_done_o1), .rx_parity_err(rx_perr_o1), .rx_frame_err(rx_ferr_o1));
    uart_core_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_n2 (
        .clk(clk), .rst(rst), .tx_start(tx_start_n2), .tx_data(tx_data_n2), .tx(tx_n2), .tx_busy(tx_busy_n2),
        .rx(rx_n2), .rx_data(rx_data_n2), .rx_done(rx_done_n2), .rx_parity_err(rx_perr_n2), .rx_frame_err(rx_ferr_n2));

    int total = 0;
    int bad   = 0;
    int done_n1 = 0, done_e1 = 0, done_o1 = 0, done_n2 = 0, rise_n2 = 0;
    logic busy_n2_prev = 1'b0;

    // rx_done high-cycle counters; a pulse longer than one clk shows up as an extra count.
    always @(posedge clk) begin
        if (rx_done_n1) done_n1 <= done_n1 + 1;
        if (rx_done_e1) done_e1 <= done_e1 + 1;
        if (rx_done_o1) done_o1 <= done_o1 + 1;
        if (rx_done_n2) done_n2 <= done_n2 + 1;
        busy_n2_prev <= tx_busy_n2;
        if (tx_busy_n2 && !busy_n2_prev) rise_n2 <= rise_n2 + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_n1 = v;
            1:       rx_o1 = v;
            default: rx_n2 = v;
        endcase
    endtask

    task automatic inject(input int sel, input logic [7:0] data, input int par_mode,
                          input int nstop, input bit flip_par, input bit stop2_low);
        logic p;
        set_rx(sel, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, data[i]);
            wait_clks(BIT_CLKS);
        end
        if (par_mode != 0) begin
            p = ^data;
            if (par_mode == 2) p = ~p;
            if (flip_par) p = ~p;
            set_rx(sel, p);
            wait_clks(BIT_CLKS);
        end
        set_rx(sel, 1'b1);
        wait_clks(BIT_CLKS);
        if (nstop == 2) begin
            set_rx(sel, stop2_low ? 1'b0 : 1'b1);
            wait_clks(BIT_CLKS);
        end
        set_rx(sel, 1'b1);
        wait_clks(40);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(3);
        total++; if (tx_n1 !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx_n1); end
        total++; if (tx_busy_n1 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", tx_busy_n1); end
        total++; if (rx_data_n1 !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h exp=00", rx_data_n1); end
        total++; if (rx_done_n1 !== 1'b0) begin bad++; $display("FAIL rst_rx_done got=%b exp=0", rx_done_n1); end
        total++; if (rx_perr_n1 !== 1'b0) begin bad++; $display("FAIL rst_perr got=%b exp=0", rx_perr_n1); end
        total++; if (rx_ferr_n1 !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b exp=0", rx_ferr_n1); end
        total++; if (tx_e1 !== 1'b1) begin bad++; $display("FAIL rst_tx_e1 got=%b exp=1", tx_e1); end
        rst = 1'b0;
        wait_clks(20);
    endtask

    task automatic test_tx_8n1();
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        tx_data_n1  = 8'h55;
        tx_start_n1 = 1'b1;
        wait_clks(1);
        tx_start_n1 = 1'b0;
        total++; if (tx_n1 !== 1'b0) begin bad++; $display("FAIL tx_start_edge got=%b exp=0", tx_n1); end
        total++; if (tx_busy_n1 !== 1'b1) begin bad++; $display("FAIL tx_busy_set got=%b exp=1", tx_busy_n1); end
        wait_clks(80);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (tx_n1 !== frame[i]) begin bad++; $display("FAIL tx_bit%0d got=%b exp=%b", i, tx_n1, frame[i]); end
            if (i < 9) wait_clks(BIT_CLKS);
        end
        wait_clks(60);
        total++; if (tx_busy_n1 !== 1'b1) begin bad++; $display("FAIL tx_busy_1580 got=%b exp=1", tx_busy_n1); end
        wait_clks(30);
        total++; if (tx_busy_n1 !== 1'b0) begin bad++; $display("FAIL tx_busy_1610 got=%b exp=0", tx_busy_n1); end
        total++; if (tx_n1 !== 1'b1) begin bad++; $display("FAIL tx_idle_high got=%b exp=1", tx_n1); end
        wait_clks(50);
    endtask

    task automatic test_loopback_8e1();
        int d0;
        int n;
        logic [7:0] data;
        logic exp_par;
        data    = 8'hA7;
        exp_par = ^data;
        d0 = done_e1;
        tx_data_e1  = data;
        tx_start_e1 = 1'b1;
        wait_clks(1);
        tx_start_e1 = 1'b0;
        wait_clks(80 + 9 * BIT_CLKS);
        total++; if (tx_e1 !== exp_par) begin bad++; $display("FAIL e1_parity_bit got=%b exp=%b", tx_e1, exp_par); end
        n = 0;
        while (done_e1 == d0 && n < 1000) begin wait_clks(1); n++; end
        wait_clks(5);
        total++; if (done_e1 != d0 + 1) begin bad++; $display("FAIL e1_done_count got=%0d exp=%0d", done_e1 - d0, 1); end
        total++; if (rx_data_e1 !== data) begin bad++; $display("FAIL e1_rx_data got=%h exp=%h", rx_data_e1, data); end
        total++; if (rx_perr_e1 !== 1'b0) begin bad++; $display("FAIL e1_perr got=%b exp=0", rx_perr_e1); end
        total++; if (rx_ferr_e1 !== 1'b0) begin bad++; $display("FAIL e1_ferr got=%b exp=0", rx_ferr_e1); end
        wait_clks(200);
    endtask

    task automatic test_parity_8o1();
        int d0;
        d0 = done_o1;
        inject(1, 8'h0F, 2, 1, 1'b1, 1'b0);
        total++; if (done_o1 != d0 + 1) begin bad++; $display("FAIL o1_done_count got=%0d exp=1", done_o1 - d0); end
        total++; if (rx_data_o1 !== 8'h0F) begin bad++; $display("FAIL o1_rx_data got=%h exp=0f", rx_data_o1); end
        total++; if (rx_perr_o1 !== 1'b1) begin bad++; $display("FAIL o1_perr_bad got=%b exp=1", rx_perr_o1); end
        total++; if (rx_ferr_o1 !== 1'b0) begin bad++; $display("FAIL o1_ferr got=%b exp=0", rx_ferr_o1); end
        inject(1, 8'h35, 2, 1, 1'b0, 1'b0);
        total++; if (rx_data_o1 !== 8'h35) begin bad++; $display("FAIL o1_rx_data2 got=%h exp=35", rx_data_o1); end
        total++; if (rx_perr_o1 !== 1'b0) begin bad++; $display("FAIL o1_perr_good got=%b exp=0", rx_perr_o1); end
    endtask

    task automatic test_glitch_8n1();
        int d0;
        d0 = done_n1;
        set_rx(0, 1'b0);
        wait_clks(40);
        set_rx(0, 1'b1);
        wait_clks(300);
        total++; if (done_n1 != d0) begin bad++; $display("FAIL glitch_no_done got=%0d exp=0", done_n1 - d0); end
        inject(0, 8'h3C, 0, 1, 1'b0, 1'b0);
        total++; if (done_n1 != d0 + 1) begin bad++; $display("FAIL glitch_frame_done got=%0d exp=1", done_n1 - d0); end
        total++; if (rx_data_n1 !== 8'h3C) begin bad++; $display("FAIL glitch_frame_data got=%h exp=3c", rx_data_n1); end
        total++; if (rx_ferr_n1 !== 1'b0) begin bad++; $display("FAIL glitch_frame_ferr got=%b exp=0", rx_ferr_n1); end
    endtask

    task automatic test_8n2();
        int d0;
        int r0;
        d0 = done_n2;
        inject(2, 8'hC5, 0, 2, 1'b0, 1'b1);
        total++; if (done_n2 != d0 + 1) begin bad++; $display("FAIL n2_done_count got=%0d exp=1", done_n2 - d0); end
        total++; if (rx_data_n2 !== 8'hC5) begin bad++; $display("FAIL n2_rx_data got=%h exp=c5", rx_data_n2); end
        total++; if (rx_ferr_n2 !== 1'b1) begin bad++; $display("FAIL n2_ferr_stop2 got=%b exp=1", rx_ferr_n2); end
        inject(2, 8'h5A, 0, 2, 1'b0, 1'b0);
        total++; if (rx_ferr_n2 !== 1'b0) begin bad++; $display("FAIL n2_ferr_clean got=%b exp=0", rx_ferr_n2); end
        r0 = rise_n2;
        tx_data_n2  = 8'h96;
        tx_start_n2 = 1'b1;
        wait_clks(1);
        tx_start_n2 = 1'b0;
        wait_clks(499);
        tx_data_n2  = 8'h69;
        tx_start_n2 = 1'b1;
        wait_clks(1);
        tx_start_n2 = 1'b0;
        wait_clks(1040 - 501);
        total++; if (tx_n2 !== 1'b0) begin bad++; $display("FAIL n2_tx_d5 got=%b exp=0", tx_n2); end
        wait_clks(1360 - 1040);
        total++; if (tx_n2 !== 1'b1) begin bad++; $display("FAIL n2_tx_d7 got=%b exp=1", tx_n2); end
        wait_clks(1740 - 1360);
        total++; if (tx_busy_n2 !== 1'b1) begin bad++; $display("FAIL n2_busy_1740 got=%b exp=1", tx_busy_n2); end
        wait_clks(30);
        total++; if (tx_busy_n2 !== 1'b0) begin bad++; $display("FAIL n2_busy_1770 got=%b exp=0", tx_busy_n2); end
        wait_clks(400);
        total++; if (rise_n2 != r0 + 1) begin bad++; $display("FAIL n2_frames_sent got=%0d exp=1", rise_n2 - r0); end
    endtask

    task automatic test_break_8n1();
        int d0;
        d0 = done_n1;
        set_rx(0, 1'b0);
        wait_clks(12 * BIT_CLKS);
        total++; if (done_n1 != d0 + 1) begin bad++; $display("FAIL break_done got=%0d exp=1", done_n1 - d0); end
        total++; if (rx_data_n1 !== 8'h00) begin bad++; $display("FAIL break_data got=%h exp=00", rx_data_n1); end
        total++; if (rx_ferr_n1 !== 1'b1) begin bad++; $display("FAIL break_ferr got=%b exp=1", rx_ferr_n1); end
        wait_clks(10 * BIT_CLKS);
        total++; if (done_n1 != d0 + 1) begin bad++; $display("FAIL break_held_done got=%0d exp=1", done_n1 - d0); end
        set_rx(0, 1'b1);
        wait_clks(100);
        inject(0, 8'hC3, 0, 1, 1'b0, 1'b0);
        total++; if (done_n1 != d0 + 2) begin bad++; $display("FAIL break_next_done got=%0d exp=2", done_n1 - d0); end
        total++; if (rx_data_n1 !== 8'hC3) begin bad++; $display("FAIL break_next_data got=%h exp=c3", rx_data_n1); end
        total++; if (rx_ferr_n1 !== 1'b0) begin bad++; $display("FAIL break_next_ferr got=%b exp=0", rx_ferr_n1); end
    endtask

    task automatic test_reset_midframe();
        int d0;
        logic [7:0] rxd;
        rxd = 8'h5A;
        d0  = done_n1;
        tx_data_n1  = 8'h3E;
        tx_start_n1 = 1'b1;
        set_rx(0, 1'b0);
        wait_clks(1);
        tx_start_n1 = 1'b0;
        wait_clks(BIT_CLKS - 1);
        for (int i = 0; i < 3; i++) begin
            set_rx(0, rxd[i]);
            wait_clks(BIT_CLKS);
        end
        set_rx(0, rxd[3]);
        wait_clks(80);
        total++; if (tx_busy_n1 !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", tx_busy_n1); end
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        set_rx(0, 1'b1);
        total++; if (tx_n1 !== 1'b1) begin bad++; $display("FAIL mid_rst_tx got=%b exp=1", tx_n1); end
        total++; if (tx_busy_n1 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", tx_busy_n1); end
        total++; if (rx_data_n1 !== 8'h00) begin bad++; $display("FAIL mid_rst_rx_data got=%h exp=00", rx_data_n1); end
        wait_clks(10 * BIT_CLKS);
        total++; if (done_n1 != d0) begin bad++; $display("FAIL mid_rst_no_done got=%0d exp=0", done_n1 - d0); end
        total++; if (tx_busy_n1 !== 1'b0) begin bad++; $display("FAIL mid_rst_tx_idle got=%b exp=0", tx_busy_n1); end
        inject(0, 8'h81, 0, 1, 1'b0, 1'b0);
        total++; if (done_n1 != d0 + 1) begin bad++; $display("FAIL mid_next_done got=%0d exp=1", done_n1 - d0); end
        total++; if (rx_data_n1 !== 8'h81) begin bad++; $display("FAIL mid_next_data got=%h exp=81", rx_data_n1); end
        total++; if (rx_ferr_n1 !== 1'b0) begin bad++; $display("FAIL mid_next_ferr got=%b exp=0", rx_ferr_n1); end
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback_8e1();
        test_parity_8o1();
        test_glitch_8n1();
        test_8n2();
        test_break_8n1();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
